// File: rtl/acc_datapath_alu.sv
// rtl/acc_datapath_alu.sv - accumulator datapath with ALU, N/Z/C/V flags and optional iterative multiplier
// Optional feature macro: ACC_DP_MUL_EN (shift-add multiplier with busy handshake)

module acc_datapath_alu #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_SHAMT   = $clog2(NB_DATA)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_ram_data,
    input  logic [NB_OPERAND-1:0] i_operand,
    input  logic [1:0]            i_sel_a,
    input  logic                  i_sel_b,
    input  logic                  i_enb_acc,
    input  logic [3:0]            i_op,
    output logic [NB_DATA-1:0]    o_ram_data,
    output logic [3:0]            o_flags,
    output logic                  o_busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [1:0] SEL_RAM  = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;

    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA-1:0]  acc;
    logic [3:0]          flags;
    logic [NB_DATA-1:0]  imm_ext;
    logic [NB_DATA-1:0]  opb;
    logic [NB_SHAMT-1:0] shamt;
    logic [NB_DATA-1:0]  alu_res;
    logic                alu_c;
    logic                alu_v;
    logic                alu_flag_op;
    logic                wr;
    logic                busy;
    logic                mul_done;
    logic [NB_DATA-1:0]  mul_lo;
    logic                mul_hi_nz;

    assign imm_ext     = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
    assign opb         = i_sel_b ? i_ram_data : imm_ext;
    assign shamt       = opb[NB_SHAMT-1:0];
    // ops 0-7 are the only ones that produce an ALU result and touch flags
    assign alu_flag_op = (i_op[3] == 1'b0);
    // the control unit's write is dropped entirely while the multiplier runs
    assign wr          = i_enb_acc & ~busy;

    // combinational ALU; the extra bit in each shift catches the last bit shifted out
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, acc} + {1'b0, opb};
                alu_v = (acc[MSB] == opb[MSB]) && (alu_res[MSB] != acc[MSB]);
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow (acc < B unsigned)
                {alu_c, alu_res} = {1'b0, acc} - {1'b0, opb};
                alu_v = (acc[MSB] != opb[MSB]) && (alu_res[MSB] != acc[MSB]);
            end
            OP_AND: alu_res = acc & opb;
            OP_OR:  alu_res = acc | opb;
            OP_XOR: alu_res = acc ^ opb;
            OP_SLL: {alu_c, alu_res} = {1'b0, acc} << shamt;
            OP_SRL: {alu_res, alu_c} = {acc, 1'b0} >> shamt;
            OP_SRA: {alu_res, alu_c} = $signed({acc, 1'b0}) >>> shamt;
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

`ifdef ACC_DP_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_RUN
    } mul_state_t;

    mul_state_t               state;
    mul_state_t               state_next;
    logic [NB_SHAMT-1:0]      mul_cnt;
    logic [2*NB_DATA-1:0]     mcand;
    logic [NB_DATA-1:0]       mplier;
    logic [2*NB_DATA-1:0]     product;
    logic [2*NB_DATA-1:0]     prod_step;
    logic                     mul_start;

    assign mul_start = wr && (i_sel_a == SEL_ALU) && (i_op == OP_MUL);
    assign prod_step = product + (mplier[0] ? mcand : '0);
    assign busy      = (state == S_RUN);
    // the last RUN cycle folds in the final partial product and retires
    assign mul_done  = (state == S_RUN) && (mul_cnt == '0);
    assign mul_lo    = prod_step[NB_DATA-1:0];
    assign mul_hi_nz = |prod_step[2*NB_DATA-1:NB_DATA];

    // multiplier state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // multiplier next-state: one pass of NB_DATA cycles through RUN
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mul_start) state_next = S_RUN;
            S_RUN:   if (mul_cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // shift-add datapath: multiplicand moves left, multiplier right, one bit per cycle
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            mul_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (mul_start) begin
                mcand   <= {{NB_DATA{1'b0}}, acc};
                mplier  <= opb;
                product <= '0;
                mul_cnt <= NB_SHAMT'(NB_DATA - 1);
            end
        end else begin
            product <= prod_step;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt - 1'b1;
        end
    end
`else
    // no multiplier: op 8 falls through as a NOP and the datapath never stalls
    assign busy      = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
`endif

    // accumulator and flag register; a retiring multiply has priority over writes
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc   <= '0;
            flags <= 4'b0000;
        end else if (mul_done) begin
            acc   <= mul_lo;
            flags <= {mul_lo[MSB], (mul_lo == '0), mul_hi_nz, 1'b0};
        end else if (wr) begin
            case (i_sel_a)
                SEL_RAM: acc <= i_ram_data;
                SEL_IMM: acc <= imm_ext;
                SEL_ALU: begin
                    if (alu_flag_op) begin
                        acc   <= alu_res;
                        flags <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
                    end
                end
                default: acc <= acc;
            endcase
        end
    end

    assign o_ram_data = acc;
    assign o_flags    = flags;
    assign o_busy     = busy;

endmodule

// File: tb/tb_acc_datapath_alu.sv
// tb/tb_acc_datapath_alu.sv - directed scoreboard bench for acc_datapath_alu

module tb_acc_datapath_alu;

    logic        clock;
    logic        reset;
    logic [15:0] ram_data;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        enb_acc;
    logic [3:0]  op;
    logic [15:0] acc_out;
    logic [3:0]  flags;
    logic        busy;

    int n_total;
    int n_pass;

    typedef struct {
        string       tag;
        logic [15:0] acc;
        logic [3:0]  flags;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    acc_datapath_alu #(
        .NB_DATA    (16),
        .NB_OPERAND (11)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_ram_data (ram_data),
        .i_operand  (operand),
        .i_sel_a    (sel_a),
        .i_sel_b    (sel_b),
        .i_enb_acc  (enb_acc),
        .i_op       (op),
        .o_ram_data (acc_out),
        .o_flags    (flags),
        .o_busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total = n_total + 1;
        assert (obs === expv) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // drive one cycle's controls, queue the expectation, clock once, compare
    task automatic step(input string tag, input logic en, input logic [1:0] sa, input logic sb,
                        input logic [3:0] o, input logic [10:0] imm, input logic [15:0] ram,
                        input logic [15:0] e_acc, input logic [3:0] e_flags, input logic e_busy);
        exp_t e;
        enb_acc  = en;
        sel_a    = sa;
        sel_b    = sb;
        op       = o;
        operand  = imm;
        ram_data = ram;
        e.tag = tag; e.acc = e_acc; e.flags = e_flags; e.busy = e_busy;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".acc"},   32'(acc_out), 32'(e.acc));
        chk({e.tag, ".flags"}, 32'(flags),   32'(e.flags));
        chk({e.tag, ".busy"},  32'(busy),    32'(e.busy));
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b1;
        enb_acc  = 1'b0;
        sel_a    = 2'b11;
        sel_b    = 1'b0;
        op       = 4'd0;
        operand  = '0;
        ram_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3; i++)
            step("idle", 1'b0, 2'b11, 1'b0, 4'd0, 11'h000, 16'h0000, 16'h0000, 4'b0000, 1'b0);

        step("ld_imm",   1'b1, 2'b01, 1'b0, 4'd0, 11'h400, 16'h0000, 16'hFC00, 4'b0000, 1'b0);
        step("ld_ram",   1'b1, 2'b00, 1'b0, 4'd0, 11'h000, 16'h7FFF, 16'h7FFF, 4'b0000, 1'b0);
        step("add_ovf",  1'b1, 2'b10, 1'b1, 4'd0, 11'h000, 16'h0001, 16'h8000, 4'b1001, 1'b0);
        step("ld_3",     1'b1, 2'b01, 1'b0, 4'd0, 11'h003, 16'h0000, 16'h0003, 4'b1001, 1'b0);
        step("sub_brw",  1'b1, 2'b10, 1'b0, 4'd1, 11'h005, 16'h0000, 16'hFFFE, 4'b1010, 1'b0);
        step("sub_zero", 1'b1, 2'b10, 1'b1, 4'd1, 11'h000, 16'hFFFE, 16'h0000, 4'b0100, 1'b0);
        step("ld_8001",  1'b1, 2'b00, 1'b0, 4'd0, 11'h000, 16'h8001, 16'h8001, 4'b0100, 1'b0);
        step("sra_1",    1'b1, 2'b10, 1'b0, 4'd7, 11'h001, 16'h0000, 16'hC000, 4'b1010, 1'b0);
        step("sll_0",    1'b1, 2'b10, 1'b0, 4'd5, 11'h000, 16'h0000, 16'hC000, 4'b1000, 1'b0);
        step("and_z",    1'b1, 2'b10, 1'b0, 4'd2, 11'h0F0, 16'h0000, 16'h0000, 4'b0100, 1'b0);
        step("xor_ram",  1'b1, 2'b10, 1'b1, 4'd4, 11'h000, 16'h1234, 16'h1234, 4'b0000, 1'b0);
        step("srl_5",    1'b1, 2'b10, 1'b0, 4'd6, 11'h005, 16'h0000, 16'h0091, 4'b0010, 1'b0);
        step("sll_12",   1'b1, 2'b10, 1'b0, 4'd5, 11'h00C, 16'h0000, 16'h1000, 4'b0010, 1'b0);
        step("or_neg",   1'b1, 2'b10, 1'b0, 4'd3, 11'h7F0, 16'h0000, 16'hFFF0, 4'b1000, 1'b0);
        step("nop_9",    1'b1, 2'b10, 1'b0, 4'd9, 11'h001, 16'h0000, 16'hFFF0, 4'b1000, 1'b0);
        step("enb_off",  1'b0, 2'b01, 1'b0, 4'd0, 11'h055, 16'h0000, 16'hFFF0, 4'b1000, 1'b0);
        step("hold",     1'b1, 2'b11, 1'b0, 4'd0, 11'h055, 16'h0000, 16'hFFF0, 4'b1000, 1'b0);
        step("ld_12",    1'b1, 2'b01, 1'b0, 4'd0, 11'h012, 16'h0000, 16'h0012, 4'b1000, 1'b0);

`ifdef ACC_DP_MUL_EN
        step("mul_start", 1'b1, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h0012, 4'b1000, 1'b1);
        for (int i = 1; i < 16; i++) begin
            if (i == 8)
                step("mul_poke", 1'b1, 2'b01, 1'b0, 4'd0, 11'h055, 16'h0034, 16'h0012, 4'b1000, 1'b1);
            else
                step("mul_run",  1'b0, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h0012, 4'b1000, 1'b1);
        end
        step("mul_done",  1'b0, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h03A8, 4'b0000, 1'b0);
        step("mul_again", 1'b1, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h03A8, 4'b0000, 1'b1);
        for (int i = 1; i < 5; i++)
            step("mul_run2", 1'b0, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h03A8, 4'b0000, 1'b1);
        reset = 1'b1;
        step("mul_abort", 1'b0, 2'b11, 1'b0, 4'd0, 11'h000, 16'h0000, 16'h0000, 4'b0000, 1'b0);
        reset = 1'b0;
        step("post_abort", 1'b0, 2'b11, 1'b0, 4'd0, 11'h000, 16'h0000, 16'h0000, 4'b0000, 1'b0);
        step("ld_after",  1'b1, 2'b00, 1'b0, 4'd0, 11'h000, 16'hA5A5, 16'hA5A5, 4'b0000, 1'b0);
`else
        step("mul_nop",   1'b1, 2'b10, 1'b1, 4'd8, 11'h000, 16'h0034, 16'h0012, 4'b1000, 1'b0);
        step("mul_nop2",  1'b0, 2'b11, 1'b0, 4'd0, 11'h000, 16'h0000, 16'h0012, 4'b1000, 1'b0);
        reset = 1'b1;
        step("reset_mid", 1'b1, 2'b01, 1'b0, 4'd0, 11'h055, 16'h0000, 16'h0000, 4'b0000, 1'b0);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
